// File: rtl/mov_monitor.sv
// mov_monitor: checks a MOV source/destination sweep.
// A start pulse arms the checker. The sweep must begin at src=1 and count up
// through every nonzero value. It ends when src returns to 0 (the wrap-around).
// Each nonzero sample is compared (dst vs src) and counted.
// Ports:
//   clk, rst_n          clock, async active-low reset (release synchronised)
//   start, sample       arm pulse, sample strobe
//   src, dst [N-1:0]    MOV source value driven, destination value returned
//   busy, done, pass    status; pass is valid while done=1
//   err_cnt, vec_cnt    saturating mismatch / vector counters [N:0]
//   seq_err             sticky sweep-order violation
//   first_bad [N-1:0]   src of the first mismatch since start (0 if none)
//
// state | meaning
// IDLE  | waiting for start after reset
// ARM   | waiting for the first vector (src=1)
// RUN   | sweep in progress, exp holds the next expected src
// DONE  | terminal vector seen, results frozen until start
module mov_monitor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sample,
  input  logic [N-1:0] src,
  input  logic [N-1:0] dst,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_cnt,
  output logic [N:0]   vec_cnt,
  output logic         seq_err,
  output logic [N-1:0] first_bad
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  localparam logic [N:0]   CNT_MAX  = {(N+1){1'b1}};
  localparam logic [N:0]   VEC_FULL = {1'b0, {N{1'b1}}};
  localparam logic [N-1:0] ONE      = N'(1);

  state_t       state_q, state_d;
  logic [1:0]   rst_sync_q;
  logic         run_en;
  logic [N:0]   err_q, err_d, vec_q, vec_d;
  logic         seq_q, seq_d, pass_q, pass_d;
  logic [N-1:0] fb_q, fb_d, exp_q, exp_d;

  // Reset asserts immediately. State may only advance after two clean edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign run_en = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      err_q   <= '0;
      vec_q   <= '0;
      seq_q   <= 1'b0;
      pass_q  <= 1'b0;
      fb_q    <= '0;
      exp_q   <= ONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      seq_q   <= seq_d;
      pass_q  <= pass_d;
      fb_q    <= fb_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    vec_d   = vec_q;
    seq_d   = seq_q;
    pass_d  = pass_q;
    fb_d    = fb_q;
    exp_d   = exp_q;
    if (run_en) begin
      if (start) begin
        // Start has priority in every state; a same-cycle sample is dropped.
        state_d = S_ARM;
        err_d   = '0;
        vec_d   = '0;
        seq_d   = 1'b0;
        pass_d  = 1'b0;
        fb_d    = '0;
        exp_d   = ONE;
      end else if (sample && (state_q == S_ARM || state_q == S_RUN)) begin
        if (state_q == S_RUN && src == '0) begin
          // Terminal vector: only the order check applies, no compare.
          seq_d   = seq_q | (exp_q != '0);
          pass_d  = (err_q == '0) && !seq_d && (vec_q == VEC_FULL);
          state_d = S_DONE;
        end else begin
          if (src != '0) begin
            if (vec_q != CNT_MAX) vec_d = vec_q + 1'b1;
            if (dst != src) begin
              if (err_q != CNT_MAX) err_d = err_q + 1'b1;
              // Compared src is never 0, so fb_q==0 means nothing captured yet.
              if (fb_q == '0) fb_d = src;
            end
          end
          if (state_q == S_ARM) begin
            if (src == ONE) begin
              state_d = S_RUN;
              exp_d   = src + ONE;
            end else begin
              seq_d = 1'b1;
            end
          end else begin
            if (src != exp_q) seq_d = 1'b1;
            exp_d = src + ONE;
          end
        end
      end
    end
  end

  assign busy      = (state_q == S_ARM) || (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign vec_cnt   = vec_q;
  assign seq_err   = seq_q;
  assign first_bad = fb_q;

endmodule

// File: doc/mov_monitor.md
MOV_MONITOR -- requirements
Module: mov_monitor

Interface
REQ-001 Parameter: N, default 4, data width of the MOV source and destination buses.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; arms a new sweep check.
REQ-005 sample  input  1  strobe; src/dst valid this cycle.
REQ-006 src  input  N  value driven into the MOV source operand.
REQ-007 dst  input  N  value returned by the MOV destination operand.
REQ-008 busy  output  1  high while in ARM or RUN.
REQ-009 done  output  1  high in DONE state.
REQ-010 pass  output  1  sweep verdict, valid when done=1.
REQ-011 err_cnt  output  N+1  count of dst!=src mismatches, saturating.
REQ-012 vec_cnt  output  N+1  count of non-terminal vectors checked.
REQ-013 seq_err  output  1  sticky; src did not follow the expected sweep order.
REQ-014 first_bad  output  N  src value of the first mismatch; 0 if none.

Function
REQ-015 FSM states: IDLE, ARM, RUN, DONE, encoded in a registered state variable.
REQ-016 IDLE: start=1 -> ARM; clears err_cnt, vec_cnt, seq_err, first_bad, pass.
REQ-017 ARM: first sample with src=1 -> RUN; sample with src!=1 -> seq_err=1, stay in ARM; sample is still compared.
REQ-018 Compare rule: on every sample in ARM/RUN with src!=0, the block increments vec_cnt and, if dst!=src, increments err_cnt.
REQ-019 err_cnt and vec_cnt saturate at 2^(N+1)-1 and do not wrap.
REQ-020 first_bad captures src on the first mismatch after start and holds until the next start or reset.
REQ-021 RUN: the block holds expected value exp (N bits). A sample with src!=exp sets seq_err. exp = src+1 mod 2^N after each sample.
REQ-022 Terminal: a sample with src=0 in RUN -> DONE; the 0 vector is not compared or counted. This is the wrap-around end of the sweep.
REQ-023 pass = (err_cnt==0) and (seq_err==0) and (vec_cnt==2^N-1); registered on the RUN->DONE transition.
REQ-024 Latency: all outputs reflect a sample exactly one clock after the edge that captured it; no combinational path from inputs to outputs.
REQ-025 DONE: outputs held stable; sample ignored; start=1 -> ARM with the same clears as REQ-016.
REQ-026 start in ARM or RUN: abort and re-arm. Counters cleared, state -> ARM, and any same-cycle sample is dropped.
REQ-027 sample in IDLE is ignored; no counter changes.
REQ-028 busy=1 in ARM/RUN only; done=1 in DONE only; never both high.

Reset
REQ-029 rst_n=0: state=IDLE, busy=0, done=0, pass=0, err_cnt=0, vec_cnt=0, seq_err=0, first_bad=0, exp=1, applied immediately and independent of clk.
REQ-030 Reset asserted mid-sweep discards all progress; after release the block waits for start.
REQ-031 Reset deassertion is synchronised internally; the first state change occurs no earlier than the second rising edge after release.

Verification
REQ-032 N=4, start, then sample with src=1..15 and dst=src, then src=0 -> done=1, pass=1, vec_cnt=15, err_cnt=0, seq_err=0, first_bad=0.
REQ-033 Same sweep with dst=src^1 at src=6 and src=9 -> pass=0, err_cnt=2, first_bad=6, vec_cnt=15.
REQ-034 Sweep skipping src=5 (4 then 6) -> seq_err=1, pass=0, vec_cnt=14.
REQ-035 rst_n=0 asserted after src=7 in RUN, then released, then full good sweep -> all outputs 0 immediately on reset; final pass=1.
REQ-036 start pulsed together with sample at src=3 in RUN -> state ARM, counters 0, that sample not counted; busy stays 1.
REQ-037 Samples in DONE with random src/dst for 10 cycles -> all outputs unchanged; then start -> busy=1, done=0.
